// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - Byte-level I2C target with fixed 7-bit address, no clock stretching
//
// Ports:
//   clk          system clock, at least 20x the SCL frequency
//   reset        synchronous active-low reset
//   scl          raw bus clock from the master
//   sda          open-drain bus data (driven 0 or released to z)
//   tx_data      next read byte, sampled at the SCL fall that ends an ACK bit
//   rx_nack      1 at a write byte's 8th SCL rise makes the slave NACK that byte
//   rx_data      last received write byte
//   rx_valid     one-cycle pulse when rx_data updates
//   tx_req       one-cycle pulse asking the host for the next read byte
//   rw           R/W bit of the last matched address byte
//   busy         addressed transaction in progress
//   master_nack  one-cycle pulse when the master NACKs a read byte
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  input  logic       rx_nack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic       master_nack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t     state, state_n;
  logic       scl_m, scl_s, scl_d;
  logic       sda_m, sda_s, sda_d;
  logic [3:0] bit_cnt, bit_cnt_n, bit_inc;
  logic [7:0] shreg, shreg_n;
  logic       sda_low, sda_low_n;
  logic       ack_phase, ack_phase_n;
  logic       nack_lat, nack_lat_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, master_nack_n, rw_n, busy_n;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Synchronizers just track the bus; leaving them out of reset avoids a
  // refill after reset being mistaken for a START/STOP edge.
  always_ff @(posedge clk) begin
    scl_m <= scl;
    scl_s <= scl_m;
    scl_d <= scl_s;
    sda_m <= sda;
    sda_s <= sda_m;
    sda_d <= sda_s;
  end

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL stable high in both samples, so these cannot coincide with an SCL edge.
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign bit_inc  = (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'h00;
      sda_low     <= 1'b0;
      ack_phase   <= 1'b0;
      nack_lat    <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      master_nack <= 1'b0;
      rw          <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      sda_low     <= sda_low_n;
      ack_phase   <= ack_phase_n;
      nack_lat    <= nack_lat_n;
      rx_data     <= rx_data_n;
      rx_valid    <= rx_valid_n;
      tx_req      <= tx_req_n;
      master_nack <= master_nack_n;
      rw          <= rw_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    sda_low_n     = sda_low;
    ack_phase_n   = ack_phase;
    nack_lat_n    = nack_lat;
    rx_data_n     = rx_data;
    rx_valid_n    = 1'b0;
    tx_req_n      = 1'b0;
    master_nack_n = 1'b0;
    rw_n          = rw;
    busy_n        = busy;
    if (start_ev || stop_ev) begin
      state_n     = start_ev ? S_ADDR : S_IDLE;
      sda_low_n   = 1'b0;
      bit_cnt_n   = 4'd0;
      ack_phase_n = 1'b0;
      busy_n      = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_inc;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd0;
              if (shreg[6:0] == SLAVE_ADDR) begin
                rw_n        = sda_s;
                busy_n      = 1'b1;
                ack_phase_n = 1'b0;
                state_n     = S_ADDR_ACK;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end
        end
        // ack_phase=0: waiting for the fall that ends bit 8; 1: inside the ACK bit.
        S_ADDR_ACK: begin
          if (scl_rise && ack_phase && rw) begin
            tx_req_n = 1'b1;
          end else if (scl_fall) begin
            if (!ack_phase) begin
              sda_low_n   = 1'b1;
              ack_phase_n = 1'b1;
            end else if (!rw) begin
              sda_low_n   = 1'b0;
              ack_phase_n = 1'b0;
              state_n     = S_WR_DATA;
            end else begin
              shreg_n     = tx_data;
              sda_low_n   = ~tx_data[7];
              bit_cnt_n   = 4'd1;
              ack_phase_n = 1'b0;
              state_n     = S_RD_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_inc;
            if (bit_cnt == 4'd7) begin
              rx_data_n   = {shreg[6:0], sda_s};
              rx_valid_n  = 1'b1;
              nack_lat_n  = rx_nack;
              bit_cnt_n   = 4'd0;
              ack_phase_n = 1'b0;
              state_n     = S_WR_ACK;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_low_n   = ~nack_lat;
              ack_phase_n = 1'b1;
            end else begin
              sda_low_n   = 1'b0;
              ack_phase_n = 1'b0;
              state_n     = S_WR_DATA;
            end
          end
        end
        // bit_cnt counts bits already presented; the shift register is not
        // shifted, the next bit is picked by index.
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_n = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = S_RD_ACK;
            end else begin
              sda_low_n = ~shreg[3'd7 - bit_cnt[2:0]];
              bit_cnt_n = bit_inc;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_n    = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              master_nack_n = 1'b1;
              busy_n        = 1'b0;
              state_n       = S_IGNORE;
            end
          end else if (scl_fall && ack_phase) begin
            shreg_n     = tx_data;
            sda_low_n   = ~tx_data[7];
            bit_cnt_n   = 4'd1;
            ack_phase_n = 1'b0;
            state_n     = S_RD_DATA;
          end
        end
        default: sda_low_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - Scoreboard bench for i2c_slave driving a bit-banged I2C master
module tb_i2c_slave;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda_low;
  logic       rx_nack;
  logic [7:0] tx_data = 8'h00;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw, busy, master_nack;

  int n_vec = 0, n_err = 0;
  int n_rxv = 0, n_txreq = 0, n_mnack = 0, n_dut_low = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] host_q[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
    .tx_data(tx_data), .rx_nack(rx_nack), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_req(tx_req), .rw(rw), .busy(busy),
    .master_nack(master_nack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor / host model: compares rx bytes against the scoreboard and
  // serves tx_req from the host queue.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      if (exp_rx.size() == 0) chk("rx_unexpected", rx_valid, 0);
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_req) begin
      n_txreq++;
      if (host_q.size() == 0) chk("txreq_unexpected", tx_req, 0);
      else tx_data = host_q.pop_front();
    end
    if (master_nack) n_mnack++;
    if (sda_bus === 1'b0 && !m_sda_low) n_dut_low++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  task automatic i2c_start();
    if (!scl) begin
      m_sda_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
    end
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(Q);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int b_rx, b_tx, b_low, b_nk;

    reset = 1'b0; scl = 1'b1; m_sda_low = 1'b0; rx_nack = 1'b0;
    wait_clk(5);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_master_nack", master_nack, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    reset = 1'b1;
    wait_clk(Q);

    // Plain write
    i2c_start();
    send_byte(8'hA0, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy, 1);
    chk("wr_rw", rw, 0);
    exp_rx.push_back(8'h3C);
    send_byte(8'h3C, ack);
    chk("wr_data_ack", ack, 0);
    i2c_stop();
    wait_clk(Q);
    chk("wr_busy_stop", busy, 0);
    chk("wr_rxv_count", n_rxv, 1);

    // Address mismatch
    b_rx = n_rxv; b_tx = n_txreq; b_low = n_dut_low;
    i2c_start();
    send_byte(8'hA2, ack);
    chk("mm_addr_ack", ack, 1);
    chk("mm_busy", busy, 0);
    send_byte(8'h55, ack);
    chk("mm_data_ack", ack, 1);
    i2c_stop();
    wait_clk(Q);
    chk("mm_rxv", n_rxv, b_rx);
    chk("mm_txreq", n_txreq, b_tx);
    chk("mm_sda_driven", n_dut_low, b_low);

    // Repeated-START read of three bytes, last one NACKed
    i2c_start();
    send_byte(8'hA0, ack);
    chk("rd_wraddr_ack", ack, 0);
    i2c_start();
    foreach (d[i]) d[i] = 1'b0;
    host_q.push_back(8'h11); exp_rd.push_back(8'h11);
    host_q.push_back(8'h22); exp_rd.push_back(8'h22);
    host_q.push_back(8'h33); exp_rd.push_back(8'h33);
    b_tx = n_txreq; b_nk = n_mnack; b_low = 0;
    send_byte(8'hA1, ack);
    chk("rd_addr_ack", ack, 0);
    chk("rd_rw", rw, 1);
    for (int k = 0; k < 3; k++) begin
      read_byte(d);
      chk("rd_byte", d, exp_rd.pop_front());
      if (k == 2) b_low = n_dut_low;
      send_bit(k == 2, s);
    end
    chk("rd_master_nack", n_mnack - b_nk, 1);
    chk("rd_busy_after_nack", busy, 0);
    i2c_stop();
    wait_clk(Q);
    chk("rd_txreq_count", n_txreq - b_tx, 3);
    chk("rd_sda_released", n_dut_low, b_low);

    // rx_nack on a write byte
    i2c_start();
    send_byte(8'hA0, ack);
    chk("nk_addr_ack", ack, 0);
    b_rx = n_rxv;
    rx_nack = 1'b1;
    exp_rx.push_back(8'h55);
    send_byte(8'h55, ack);
    rx_nack = 1'b0;
    chk("nk_data_ack", ack, 1);
    chk("nk_rxv", n_rxv - b_rx, 1);
    i2c_stop();
    wait_clk(Q);

    // STOP after five data bits, then a byte without START must be ignored
    i2c_start();
    send_byte(8'hA0, ack);
    chk("sp_addr_ack", ack, 0);
    b_rx = n_rxv;
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    send_bit(1'b1, s); send_bit(1'b0, s);
    i2c_stop();
    wait_clk(Q);
    chk("sp_busy", busy, 0);
    chk("sp_rxv", n_rxv, b_rx);
    scl = 1'b0;
    wait_clk(Q);
    send_byte(8'hA0, ack);
    chk("sp_idle_no_ack", ack, 1);
    i2c_stop();
    wait_clk(Q);

    // Reset during bit 4 of a read byte (0xE5: fourth bit is 0, slave drives low)
    host_q.push_back(8'hE5);
    i2c_start();
    send_byte(8'hA1, ack);
    chk("rr_addr_ack", ack, 0);
    send_bit(1'b1, s); chk("rr_bit7", s, 1);
    send_bit(1'b1, s); chk("rr_bit6", s, 1);
    send_bit(1'b1, s); chk("rr_bit5", s, 1);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    chk("rr_bit4_driven", sda_bus, 0);
    reset = 1'b0;
    wait_clk(1);
    chk("rr_sda_released", sda_bus, 1);
    chk("rr_busy", busy, 0);
    chk("rr_rw", rw, 0);
    chk("rr_rx_data", rx_data, 8'h00);
    chk("rr_tx_req", tx_req, 0);
    wait_clk(4);
    scl = 1'b0;
    wait_clk(Q);
    reset = 1'b1;
    wait_clk(Q);
    i2c_start();
    send_byte(8'hA0, ack);
    chk("rr_fresh_ack", ack, 0);
    chk("rr_fresh_busy", busy, 1);
    i2c_stop();
    wait_clk(Q);
    chk("rr_stop_busy", busy, 0);

    chk("rx_q_empty", exp_rx.size(), 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("host_q_empty", host_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
